// File: rtl/packet_disassembler.sv
`default_nettype none
// ============================================================================
// Module   : packet_disassembler
// Purpose  : Rebuilds HDMI data island packets from 32 beats of 9-bit words
//            and checks the five BCH ECC bytes.
// Revision : 1.0
// ============================================================================
module packet_disassembler #(
    parameter int ERR_COUNT_WIDTH = 16
) (
    input  logic                       clk_pixel,
    input  logic                       reset,
    input  logic                       data_island_period,
    input  logic [8:0]                 packet_data,
    output logic [23:0]                header,
    output logic [3:0][55:0]           sub,
    output logic [4:0]                 ecc_ok,
    output logic                       packet_valid,
    output logic [ERR_COUNT_WIDTH-1:0] err_count
);

    localparam logic [4:0]                 C_LAST_BEAT = 5'd31;
    localparam logic [4:0]                 C_BEAT_ONE  = 5'd1;
    localparam logic [ERR_COUNT_WIDTH-1:0] C_ERR_ONE   = 1;

    function automatic logic [7:0] ecc_step(input logic [7:0] e, input logic b);
        return {1'b0, e[7:1]} ^ ((e[0] ^ b) ? 8'h83 : 8'h00);
    endfunction

    logic [4:0]       r_beat;
    logic [3:0][63:0] r_blk;
    logic [31:0]      r_hdr;
    logic [3:0][7:0]  r_ecc;
    logic [7:0]       r_hecc;

    logic [3:0][63:0] w_blk_full;
    logic [31:0]      w_hdr_full;
    logic [3:0][7:0]  w_ecc_next;
    logic [7:0]       w_hecc_next;
    logic [4:0]       w_ok;

    // Shift registers fill from the top, so after beat 31 bit 0 holds beat 0.
    // The ECC seed is forced to zero on beat 0 so wrapped packets start fresh.
    always_comb begin
        w_hdr_full  = {packet_data[0], r_hdr[31:1]};
        w_hecc_next = r_hecc;
        if (r_beat < 5'd24)
            w_hecc_next = ecc_step((r_beat == 5'd0) ? 8'h00 : r_hecc, packet_data[0]);
        w_ok        = 5'h00;
        w_ok[4]     = (r_hecc == w_hdr_full[31:24]);
        w_blk_full  = r_blk;
        w_ecc_next  = r_ecc;
        for (int i = 0; i < 4; i++) begin
            w_blk_full[i] = {packet_data[5+i], packet_data[1+i], r_blk[i][63:2]};
            if (r_beat < 5'd28)
                w_ecc_next[i] = ecc_step(ecc_step((r_beat == 5'd0) ? 8'h00 : r_ecc[i],
                                                  packet_data[1+i]), packet_data[5+i]);
            w_ok[i] = (r_ecc[i] == w_blk_full[i][63:56]);
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_beat       <= '0;
            r_blk        <= '0;
            r_hdr        <= '0;
            r_ecc        <= '0;
            r_hecc       <= '0;
            header       <= '0;
            sub          <= '0;
            ecc_ok       <= '0;
            packet_valid <= 1'b0;
            err_count    <= '0;
        end else begin
            packet_valid <= 1'b0;
            if (!data_island_period) begin
                r_beat <= '0;
                r_blk  <= '0;
                r_hdr  <= '0;
                r_ecc  <= '0;
                r_hecc <= '0;
            end else begin
                r_beat <= r_beat + C_BEAT_ONE;
                r_blk  <= w_blk_full;
                r_hdr  <= w_hdr_full;
                r_ecc  <= w_ecc_next;
                r_hecc <= w_hecc_next;
                if (r_beat == C_LAST_BEAT) begin
                    header       <= w_hdr_full[23:0];
                    for (int i = 0; i < 4; i++)
                        sub[i] <= w_blk_full[i][55:0];
                    ecc_ok       <= w_ok;
                    packet_valid <= 1'b1;
                    if (w_ok != 5'h1F && err_count != '1)
                        err_count <= err_count + C_ERR_ONE;
                end
            end
        end
    end

endmodule
`default_nettype wire
